// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin front end that shares one AXI4-Lite master command port.
// Serialises requests: grant, start pulse, wait (with timeout), respond.
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDRESS-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ-1:0]            rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          read_s,
  output logic                          write_s,
  output logic [ADDRESS-1:0]            address,
  output logic [DATA_WIDTH-1:0]         W_data,
  input  logic [DATA_WIDTH-1:0]         read_data_out,
  input  logic                          read_valid_out,
  input  logic                          write_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = IW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDRESS-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [NUM_REQ-1:0]    rdy_q, rdy_d;
  logic [NUM_REQ-1:0]    rspv_q, rspv_d;
  logic [NUM_REQ-1:0]    rspe_q, rspe_d;
  logic                  rds_q, rds_d;
  logic                  wrs_q, wrs_d;
  logic                  busy_q, busy_d;

  logic [ADDRESS-1:0]    addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  logic                  found;
  logic [IW-1:0]         win;
  logic [PW-1:0]         idx;
  logic                  done;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDRESS +: ADDRESS];
    assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first pending requester at or after rr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + PW'(k);
      if (idx >= PW'(NUM_REQ)) begin
        idx = idx - PW'(NUM_REQ);
      end
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  // Only the completion matching the latched op type counts.
  always_comb begin
    done = op_wr_q ? write_done : read_valid_out;
  end

  // Next state, latched transaction fields and registered pulses.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    tcnt_d  = tcnt_q;
    rdy_d   = '0;
    rspv_d  = '0;
    rspe_d  = '0;
    rds_d   = 1'b0;
    wrs_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_ISSUE;
          gnt_d      = win;
          op_wr_d    = req_write[win];
          addr_d     = addr_a[win];
          wdata_d    = wdata_a[win];
          rdy_d[win] = 1'b1;
          rds_d      = !req_write[win];
          wrs_d      = req_write[win];
          if (win == IW'(NUM_REQ - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = win + IW'(1);
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (done) begin
          state_d       = S_RESP;
          rspv_d[gnt_q] = 1'b1;
          if (!op_wr_q) begin
            rdata_d = read_data_out;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d       = S_RESP;
          rspv_d[gnt_q] = 1'b1;
          rspe_d[gnt_q] = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // busy mirrors the state the FSM is entering, so it is a flop too.
  always_comb begin
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tcnt_q  <= '0;
      rdy_q   <= '0;
      rspv_q  <= '0;
      rspe_q  <= '0;
      rds_q   <= 1'b0;
      wrs_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tcnt_q  <= tcnt_d;
      rdy_q   <= rdy_d;
      rspv_q  <= rspv_d;
      rspe_q  <= rspe_d;
      rds_q   <= rds_d;
      wrs_q   <= wrs_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rspv_q;
  assign rsp_err   = rspe_q;
  assign rsp_rdata = rdata_q;
  assign read_s    = rds_q;
  assign write_s   = wrs_q;
  assign address   = addr_q;
  assign W_data    = wdata_q;
  assign busy      = busy_q;
  assign grant_id  = gnt_q;

endmodule
